// File: rtl/regfile_lrstack.sv
// Register file (two combinational read ports, one write port) plus a LIFO link
// stack of return addresses with sticky overflow/underflow flags.
module regfile_lrstack #(
    parameter int DW       = 8,
    parameter int NREG     = 4,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1,
    parameter int PCW      = 8,
    parameter int LR_DEPTH = 4,
    parameter int CW       = $clog2(LR_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  logic [AW-1:0]  wa,
    input  logic [DW-1:0]  wdata,
    input  logic [AW-1:0]  ra1,
    input  logic [AW-1:0]  ra2,
    output logic [DW-1:0]  rd1,
    output logic [DW-1:0]  rd2,
    input  logic           push,
    input  logic [PCW-1:0] push_addr,
    input  logic           pop,
    output logic [PCW-1:0] lr_top,
    output logic [CW-1:0]  lr_count,
    output logic           lr_empty,
    output logic           lr_full,
    output logic           ovf,
    output logic           unf,
    input  logic           clr_err
);

    logic [DW-1:0]  regs_q  [NREG];
    logic [DW-1:0]  regs_d  [NREG];
    logic [PCW-1:0] stack_q [LR_DEPTH];
    logic [PCW-1:0] stack_d [LR_DEPTH];
    logic [CW-1:0]  sp_q, sp_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           wr_ok_s, ovf_set_s, unf_set_s, empty_s, full_s;
    logic [DW-1:0]  rd1_s, rd2_s;
    logic [PCW-1:0] top_s;

    // Register write decode; wr_ok_s is low for dropped writes (R0 hardwired or out of range)
    always_comb begin
        wr_ok_s = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (we && (wa == AW'(i)) && !((ZERO_R0 != 0) && (i == 0))) begin
                regs_d[i] = wdata;
                wr_ok_s   = 1'b1;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    // Read ports: unmatched addresses fall through to zero; bypass only for accepted writes
    always_comb begin
        rd1_s = {DW{1'b0}};
        rd2_s = {DW{1'b0}};
        for (int i = 0; i < NREG; i++) begin
            if (!((ZERO_R0 != 0) && (i == 0))) begin
                rd1_s = (ra1 == AW'(i)) ? regs_q[i] : rd1_s;
                rd2_s = (ra2 == AW'(i)) ? regs_q[i] : rd2_s;
            end else begin
                rd1_s = rd1_s;
                rd2_s = rd2_s;
            end
        end
        if ((BYPASS != 0) && wr_ok_s) begin
            rd1_s = (wa == ra1) ? wdata : rd1_s;
            rd2_s = (wa == ra2) ? wdata : rd2_s;
        end else begin
            rd1_s = rd1_s;
            rd2_s = rd2_s;
        end
    end

    assign empty_s = (sp_q == {CW{1'b0}});
    assign full_s  = (sp_q == CW'(LR_DEPTH));

    // Link stack next state; push+pop on a non-empty stack overwrites the top in place
    always_comb begin
        stack_d   = stack_q;
        sp_d      = sp_q;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full_s) begin
                    for (int i = 0; i < LR_DEPTH; i++)
                        stack_d[i] = (sp_q == CW'(i)) ? push_addr : stack_q[i];
                    sp_d = sp_q + CW'(1);
                end else begin
                    ovf_set_s = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_s) begin
                    sp_d = sp_q - CW'(1);
                end else begin
                    unf_set_s = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_s) begin
                    for (int i = 0; i < LR_DEPTH; i++)
                        stack_d[i] = (sp_q == CW'(i + 1)) ? push_addr : stack_q[i];
                end else begin
                    stack_d[0] = push_addr;
                    sp_d       = CW'(1);
                    unf_set_s  = 1'b1;
                end
            end
            default: sp_d = sp_q;
        endcase
        ovf_d = ovf_set_s | (ovf_q & ~clr_err);
        unf_d = unf_set_s | (unf_q & ~clr_err);
    end

    // Top-of-stack view taken from registered state only
    always_comb begin
        top_s = {PCW{1'b0}};
        for (int i = 0; i < LR_DEPTH; i++)
            top_s = (sp_q == CW'(i + 1)) ? stack_q[i] : top_s;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)     regs_q[i]  <= {DW{1'b0}};
            for (int i = 0; i < LR_DEPTH; i++) stack_q[i] <= {PCW{1'b0}};
            sp_q  <= {CW{1'b0}};
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            stack_q <= stack_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign rd1      = rd1_s;
    assign rd2      = rd2_s;
    assign lr_top   = top_s;
    assign lr_count = sp_q;
    assign lr_empty = empty_s;
    assign lr_full  = full_s;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_regfile_lrstack.sv
// Directed bench: default instance plus a ZERO_R0=1/BYPASS=0 instance on shared inputs.
module tb_regfile_lrstack;
    logic       clk, rst_n, we, push, pop, clr_err;
    logic [1:0] wa, ra1, ra2;
    logic [7:0] wdata, push_addr;
    logic [7:0] rd1, rd2, lr_top, rd1_z, rd2_z, lr_top_z;
    logic [2:0] lr_count, lr_count_z;
    logic       lr_empty, lr_full, ovf, unf, lr_empty_z, lr_full_z, ovf_z, unf_z;
    int         n_checks = 0;
    int         n_fail   = 0;

    regfile_lrstack dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .push(push), .push_addr(push_addr), .pop(pop), .lr_top(lr_top),
        .lr_count(lr_count), .lr_empty(lr_empty), .lr_full(lr_full),
        .ovf(ovf), .unf(unf), .clr_err(clr_err)
    );

    regfile_lrstack #(.ZERO_R0(1), .BYPASS(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wdata(wdata),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z),
        .push(push), .push_addr(push_addr), .pop(pop), .lr_top(lr_top_z),
        .lr_count(lr_count_z), .lr_empty(lr_empty_z), .lr_full(lr_full_z),
        .ovf(ovf_z), .unf(unf_z), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle(); wa = 2'd0; wdata = 8'h00; ra1 = 2'd2; ra2 = 2'd3; push_addr = 8'h00;
        #3;
        n_checks++; if (rd1 !== 8'h00) begin n_fail++; $display("FAIL reset_rd1 got %h exp 00", rd1); end
        n_checks++; if (rd2 !== 8'h00) begin n_fail++; $display("FAIL reset_rd2 got %h exp 00", rd2); end
        n_checks++; if (lr_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", lr_empty); end
        n_checks++; if (lr_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", lr_full); end
        n_checks++; if (lr_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", lr_count); end
        n_checks++; if (lr_top !== 8'h00) begin n_fail++; $display("FAIL reset_top got %h exp 00", lr_top); end
        n_checks++; if ({ovf, unf} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", {ovf, unf}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_rf_write();
        we = 1'b1; wa = 2'd2; wdata = 8'hA5; tick();
        wa = 2'd3; wdata = 8'h3C; tick();
        we = 1'b0; ra1 = 2'd2; ra2 = 2'd3; #1;
        n_checks++; if (rd1 !== 8'hA5) begin n_fail++; $display("FAIL rf_rd1 got %h exp a5", rd1); end
        n_checks++; if (rd2 !== 8'h3C) begin n_fail++; $display("FAIL rf_rd2 got %h exp 3c", rd2); end
        n_checks++; if (rd1_z !== 8'hA5) begin n_fail++; $display("FAIL rf_z_rd1 got %h exp a5", rd1_z); end
        n_checks++; if (rd2_z !== 8'h3C) begin n_fail++; $display("FAIL rf_z_rd2 got %h exp 3c", rd2_z); end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 2'd1; wdata = 8'h77; ra1 = 2'd1; ra2 = 2'd1; #1;
        n_checks++; if (rd1 !== 8'h77) begin n_fail++; $display("FAIL byp_rd1 got %h exp 77", rd1); end
        n_checks++; if (rd2 !== 8'h77) begin n_fail++; $display("FAIL byp_rd2 got %h exp 77", rd2); end
        n_checks++; if (rd1_z !== 8'h00) begin n_fail++; $display("FAIL nobyp_before got %h exp 00", rd1_z); end
        tick();
        we = 1'b0; #1;
        n_checks++; if (rd1_z !== 8'h77) begin n_fail++; $display("FAIL nobyp_after got %h exp 77", rd1_z); end
        n_checks++; if (rd2 !== 8'h77) begin n_fail++; $display("FAIL byp_held got %h exp 77", rd2); end
    endtask

    task automatic test_zero_r0();
        we = 1'b1; wa = 2'd0; wdata = 8'hFF; ra1 = 2'd0; ra2 = 2'd2; #1;
        n_checks++; if (rd1 !== 8'hFF) begin n_fail++; $display("FAIL r0_byp_default got %h exp ff", rd1); end
        tick();
        we = 1'b0; #1;
        n_checks++; if (rd1_z !== 8'h00) begin n_fail++; $display("FAIL r0_zero got %h exp 00", rd1_z); end
        n_checks++; if (rd2_z !== 8'hA5) begin n_fail++; $display("FAIL r0_other got %h exp a5", rd2_z); end
        n_checks++; if (rd1 !== 8'hFF) begin n_fail++; $display("FAIL r0_normal got %h exp ff", rd1); end
    endtask

    task automatic test_stack_fill();
        logic [7:0] pushes [4];
        logic [7:0] tops [4];
        pushes = '{8'h10, 8'h20, 8'h30, 8'h40};
        tops   = '{8'h30, 8'h20, 8'h10, 8'h00};
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_addr = pushes[i];
            #1;
            n_checks++; if (lr_count !== 3'(i)) begin n_fail++; $display("FAIL push_no_comb_path[%0d] got %0d exp %0d", i, lr_count, i); end
            tick();
            n_checks++; if (lr_top !== pushes[i]) begin n_fail++; $display("FAIL push_top[%0d] got %h exp %h", i, lr_top, pushes[i]); end
        end
        push_addr = 8'h50; tick(); push = 1'b0;
        n_checks++; if (lr_full !== 1'b1) begin n_fail++; $display("FAIL full got %b exp 1", lr_full); end
        n_checks++; if (lr_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count got %0d exp 4", lr_count); end
        n_checks++; if (lr_top !== 8'h40) begin n_fail++; $display("FAIL ovf_top got %h exp 40", lr_top); end
        n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf got %b exp 1", ovf); end
        n_checks++; if (unf !== 1'b0) begin n_fail++; $display("FAIL ovf_unf got %b exp 0", unf); end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1; tick();
            n_checks++; if (lr_top !== tops[i]) begin n_fail++; $display("FAIL pop_top[%0d] got %h exp %h", i, lr_top, tops[i]); end
        end
        pop = 1'b0;
        n_checks++; if (lr_empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty got %b exp 1", lr_empty); end
        n_checks++; if (unf !== 1'b0) begin n_fail++; $display("FAIL pop_unf got %b exp 0", unf); end
    endtask

    task automatic test_underflow();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf got %b exp 0", ovf); end
        pop = 1'b1; tick(); pop = 1'b0;
        n_checks++; if (unf !== 1'b1) begin n_fail++; $display("FAIL unf got %b exp 1", unf); end
        n_checks++; if (lr_count !== 3'd0) begin n_fail++; $display("FAIL unf_count got %0d exp 0", lr_count); end
        tick();
        n_checks++; if (unf !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got %b exp 1", unf); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        n_checks++; if (unf !== 1'b0) begin n_fail++; $display("FAIL clr_unf got %b exp 0", unf); end
        clr_err = 1'b1; pop = 1'b1; tick(); clr_err = 1'b0; pop = 1'b0;
        n_checks++; if (unf !== 1'b1) begin n_fail++; $display("FAIL clr_vs_unf got %b exp 1", unf); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
    endtask

    task automatic test_push_pop();
        push = 1'b1; push_addr = 8'h10; tick();
        push_addr = 8'h20; tick();
        pop = 1'b1; push_addr = 8'h99; tick();
        push = 1'b0; pop = 1'b0;
        n_checks++; if (lr_count !== 3'd2) begin n_fail++; $display("FAIL pp_count got %0d exp 2", lr_count); end
        n_checks++; if (lr_top !== 8'h99) begin n_fail++; $display("FAIL pp_top got %h exp 99", lr_top); end
        n_checks++; if (unf !== 1'b0) begin n_fail++; $display("FAIL pp_unf got %b exp 0", unf); end
        pop = 1'b1; tick();
        n_checks++; if (lr_top !== 8'h10) begin n_fail++; $display("FAIL pp_below got %h exp 10", lr_top); end
        tick(); pop = 1'b0;
        push = 1'b1; pop = 1'b1; push_addr = 8'h55; tick();
        push = 1'b0; pop = 1'b0;
        n_checks++; if (lr_count !== 3'd1) begin n_fail++; $display("FAIL pp_empty_count got %0d exp 1", lr_count); end
        n_checks++; if (lr_top !== 8'h55) begin n_fail++; $display("FAIL pp_empty_top got %h exp 55", lr_top); end
        n_checks++; if (unf !== 1'b1) begin n_fail++; $display("FAIL pp_empty_unf got %b exp 1", unf); end
    endtask

    task automatic test_full_push_pop();
        push = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_addr = 8'hA0 + 8'(i); tick();
        end
        pop = 1'b1; push_addr = 8'hEE; tick();
        push = 1'b0; pop = 1'b0;
        n_checks++; if (lr_count !== 3'd4) begin n_fail++; $display("FAIL fpp_count got %0d exp 4", lr_count); end
        n_checks++; if (lr_top !== 8'hEE) begin n_fail++; $display("FAIL fpp_top got %h exp ee", lr_top); end
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_async_reset();
        ra1 = 2'd2; ra2 = 2'd3; #1;
        n_checks++; if (rd1 !== 8'hA5) begin n_fail++; $display("FAIL pre_rst_rd1 got %h exp a5", rd1); end
        #1; rst_n = 1'b0; #1;
        n_checks++; if (lr_count !== 3'd0) begin n_fail++; $display("FAIL arst_count got %0d exp 0", lr_count); end
        n_checks++; if (rd1 !== 8'h00) begin n_fail++; $display("FAIL arst_rd1 got %h exp 00", rd1); end
        n_checks++; if (rd2 !== 8'h00) begin n_fail++; $display("FAIL arst_rd2 got %h exp 00", rd2); end
        n_checks++; if ({ovf, unf} !== 2'b00) begin n_fail++; $display("FAIL arst_err got %b exp 00", {ovf, unf}); end
        we = 1'b1; wa = 2'd2; wdata = 8'h11; push = 1'b1; push_addr = 8'h22;
        tick();
        idle(); rst_n = 1'b1; #1;
        n_checks++; if (rd1 !== 8'h00) begin n_fail++; $display("FAIL arst_hold_rd1 got %h exp 00", rd1); end
        n_checks++; if (lr_empty !== 1'b1) begin n_fail++; $display("FAIL arst_hold_empty got %b exp 1", lr_empty); end
    endtask

    initial begin
        test_reset();
        test_rf_write();
        test_bypass();
        test_zero_r0();
        test_stack_fill();
        test_underflow();
        test_push_pop();
        test_full_push_pop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
